// File: rtl/led_watch_pkg.sv
// led_watch_pkg
// Shared defaults and the record-width helper for the LED change monitor.
// Build option: LED_WATCH_TS_EN -- when defined, each record carries a
// cycle timestamp above the LED pattern; otherwise a record is the LED
// pattern alone.
package led_watch_pkg;

  localparam int                DEF_WIDTH        = 8;
  localparam int                DEF_DEPTH        = 16;
  localparam int                DEF_TS_WIDTH     = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_STOP_PATTERN = 8'b1110_0000;

  // Width of one buffered record. The timestamp width only contributes
  // when the timestamp build option is enabled.
  function automatic int rec_width(input int w, input int tsw);
    int ts_bits;
`ifdef LED_WATCH_TS_EN
    ts_bits = tsw;
`else
    ts_bits = tsw * 0;
`endif
    return w + ts_bits;
  endfunction

endpackage

// File: rtl/led_watch_fifo.sv
// led_watch_fifo
// Synchronous first-word-fall-through FIFO for led_watch records.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset
//   push   in   write data_in (ignored when full unless popping this edge)
//   pop    in   discard head (ignored when empty)
//   flush  in   empty the FIFO; wins over push and pop
//   data_in  in  DW   record to write
//   data_out out DW   head record, zero when empty
//   count  out  occupancy, $clog2(DEPTH)+1 bits
//   full   out  count == DEPTH
//   empty  out  count == 0
module led_watch_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              data_in,
  output logic [DW-1:0]              data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a write when the head leaves in the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Masking the read keeps the head at zero while nothing is buffered.
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush && reset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/led_watch.sv
// led_watch
// Watches an LED bus and records every change (optionally timestamped) into
// a FIFO drained over a valid/ready stream. Capture halts once the stop
// pattern has been seen, until clear or reset.
// Build option: LED_WATCH_TS_EN -- adds the timestamp counter and widens
// each record to {ts, leds}.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   leds       in   WIDTH   monitored bus
//   clear      in   flush FIFO, clear flags, restart timestamp
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts head record
//   out_data   out  head record
//   count      out  FIFO occupancy
//   overflow   out  sticky, a record was dropped
//   stopped    out  sticky, stop pattern captured
module led_watch
  import led_watch_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               DEPTH        = DEF_DEPTH,
  parameter int               TS_WIDTH     = DEF_TS_WIDTH,
  parameter logic [WIDTH-1:0] STOP_PATTERN = DEF_STOP_PATTERN
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WIDTH-1:0]                     leds,
  input  logic                                 clear,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [rec_width(WIDTH, TS_WIDTH)-1:0] out_data,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 overflow,
  output logic                                 stopped
);

  localparam int RW = rec_width(WIDTH, TS_WIDTH);

  logic [WIDTH-1:0] prev;
  logic [RW-1:0]    record;
  logic             change;
  logic             pop;
  logic             can_push;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;

  assign change    = (leds != prev) && !stopped;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign can_push  = !fifo_full || pop;
  assign push      = change && can_push && !clear;

`ifdef LED_WATCH_TS_EN
  logic [TS_WIDTH-1:0] ts;

  // Free-running cycle stamp; clear restarts it so a re-armed trace begins at 0.
  always_ff @(posedge clk) begin
    if (!reset || clear) ts <= '0;
    else                 ts <= ts + TS_WIDTH'(1);
  end

  assign record = {ts, leds};
`else
  assign record = leds;
`endif

  // prev follows the bus every edge, even while stopped or clearing, so
  // re-arming never reports a stale difference.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev     <= '0;
      overflow <= 1'b0;
      stopped  <= 1'b0;
    end else begin
      prev <= leds;
      if (clear) begin
        overflow <= 1'b0;
        stopped  <= 1'b0;
      end else if (change) begin
        if (!can_push)             overflow <= 1'b1;
        if (leds == STOP_PATTERN)  stopped  <= 1'b1;
      end
    end
  end

  led_watch_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (clear),
    .data_in  (record),
    .data_out (out_data),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_led_watch.sv
// tb_led_watch
// Directed bench for led_watch: a vector table for reset and basic
// push/pop, then hand-written sequences for throughput, overflow, stop,
// clear and mid-run reset. Works with LED_WATCH_TS_EN defined or not.
module tb_led_watch;
  import led_watch_pkg::*;

  localparam int RW = rec_width(DEF_WIDTH, DEF_TS_WIDTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    leds = 8'h00;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic [4:0]    count;
  logic          overflow;
  logic          stopped;

  int            check_count = 0;
  int            pass_count  = 0;
  logic [15:0]   ts_model = 16'd0;
  logic [15:0]   edge_ts;
  logic [RW-1:0] q [$];

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        rdy;
    logic [7:0]  in_leds;
    logic        e_valid;
    logic [15:0] e_ts;
    logic [7:0]  e_leds;
    int          e_count;
    logic        e_ovf;
    logic        e_stp;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  led_watch dut (
    .clk       (clk),
    .reset     (reset),
    .leds      (leds),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .stopped   (stopped)
  );

  function automatic logic [RW-1:0] mk_rec(input logic [15:0] ts, input logic [7:0] l);
`ifdef LED_WATCH_TS_EN
    return {ts, l};
`else
    return RW'(l) | RW'(ts & 16'h0000);
`endif
  endfunction

  // Drive inputs mid-cycle, let one rising edge pass, sample 1 time unit later.
  task automatic applyStimulus(input logic r, input logic c, input logic rdy,
                               input logic [7:0] l);
    @(negedge clk);
    reset     = r;
    clear     = c;
    out_ready = rdy;
    leds      = l;
    edge_ts   = ts_model;
    @(posedge clk);
    #1;
    if (!r || c) ts_model = 16'd0;
    else         ts_model = ts_model + 16'd1;
  endtask

  task automatic check_field(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag, input logic e_valid,
                             input logic [RW-1:0] e_data, input int e_count,
                             input logic e_ovf, input logic e_stp);
    check_field({tag, ".valid"},    32'(out_valid), 32'(e_valid));
    check_field({tag, ".data"},     32'(out_data),  32'(e_data));
    check_field({tag, ".count"},    32'(count),     32'(e_count));
    check_field({tag, ".overflow"}, 32'(overflow),  32'(e_ovf));
    check_field({tag, ".stopped"},  32'(stopped),   32'(e_stp));
  endtask

  initial begin
    // rst_n clr rdy leds | valid ts leds count ovf stp
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 8'h00, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 8'h00, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 8'h00, 0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 16'd2, 8'h01, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 16'd2, 8'h01, 1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 16'd2, 8'h01, 2, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 16'd4, 8'h03, 1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 16'd6, 8'h07, 1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 16'd0, 8'h00, 0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 16'd0, 8'h00, 0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].clr, vecs[i].rdy, vecs[i].in_leds);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_valid,
                  vecs[i].e_valid ? mk_rec(vecs[i].e_ts, vecs[i].e_leds) : '0,
                  vecs[i].e_count, vecs[i].e_ovf, vecs[i].e_stp);
    end

    // Walking one on consecutive cycles with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h01 << i);
      checkOutput($sformatf("walk%0d", i), 1'b1, mk_rec(edge_ts, 8'h01 << i), 1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h80);
    checkOutput("walk_end", 1'b0, '0, 0, 1'b0, 1'b0);

    // Fill to capacity, push+pop while full, then overflow and drain.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h80);
    checkOutput("clr1", 1'b0, '0, 0, 1'b0, 1'b0);
    q.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
      q.push_back(mk_rec(edge_ts, 8'h10 + 8'(i)));
      checkOutput($sformatf("fill%0d", i), 1'b1, q[0], i + 1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
    void'(q.pop_front());
    q.push_back(mk_rec(edge_ts, 8'h99));
    checkOutput("full_pushpop", 1'b1, q[0], 16, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
      checkOutput($sformatf("drop%0d", i), 1'b1, q[0], 16, 1'b1, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h43);
      void'(q.pop_front());
      if (q.size() > 0)
        checkOutput($sformatf("drain%0d", i), 1'b1, q[0], q.size(), 1'b1, 1'b0);
      else
        checkOutput($sformatf("drain%0d", i), 1'b0, '0, 0, 1'b1, 1'b0);
    end

    // Stop pattern: captured itself, later changes ignored, clear re-arms.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h43);
    checkOutput("clr2", 1'b0, '0, 0, 1'b0, 1'b0);
    q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0F);
    q.push_back(mk_rec(edge_ts, 8'h0F));
    checkOutput("pre_stop", 1'b1, q[0], 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hE0);
    q.push_back(mk_rec(edge_ts, 8'hE0));
    checkOutput("stop", 1'b1, q[0], 2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h55);
    checkOutput("after_stop", 1'b1, q[0], 2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55);
    void'(q.pop_front());
    checkOutput("stop_rec", 1'b1, q[0], 1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    checkOutput("clr3", 1'b0, '0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
    checkOutput("rearm", 1'b1, mk_rec(16'd0, 8'hAA), 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    checkOutput("clr_change", 1'b0, '0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
    checkOutput("clr_prev", 1'b0, '0, 0, 1'b0, 1'b0);

    // Mid-run reset with 5 buffered records and overflow set.
    q.delete();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h01 + 8'(i));
      if (i < 16) q.push_back(mk_rec(edge_ts, 8'h01 + 8'(i)));
    end
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    checkOutput("pre_reset", 1'b1, q[0], 5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h11);
    checkOutput("reset", 1'b0, '0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h11);
    checkOutput("post_reset", 1'b1, mk_rec(16'd0, 8'h11), 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
